// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default constants for the pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 15;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = 1;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/freeze controller for a 5-stage pipeline with memory-wait
// timeout and saturating stall/flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_stall,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             cnt_clr,
  output logic             pc_ld,
  output logic             if_id_ld,
  output logic             id_ex_ld,
  output logic             ex_mem_ld,
  output logic             mem_wb_ld,
  output logic             if_id_flush,
  output logic             id_nop,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = 1;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [4:0]        ld;

  assign {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld} = ld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    ld          = '0;
    if_id_flush = 1'b0;
    id_nop      = 1'b0;
    timeout     = 1'b0;
    // Reset gates the Mealy outputs directly, so the pipeline freezes without a clock.
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (mem_req && !mem_ack) begin
            state_nxt = MEM_WAIT;
            wait_nxt  = WAIT_ONE;
          end else if (hz_stall) begin
            ld     = 5'b00111;
            id_nop = 1'b1;
          end else begin
            ld          = '1;
            if_id_flush = br_taken;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            ld        = '1;
            state_nxt = RUN;
            wait_nxt  = '0;
          end else if (wait_cnt == WAIT_MAX) begin
            state_nxt = ERR;
          end else begin
            wait_nxt = wait_cnt + WAIT_ONE;
          end
        end
        ERR: timeout = 1'b1;
        default: state_nxt = RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (!pc_ld && (state != ERR)),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (if_id_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corner cases
// and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  localparam logic [6:0] C_NORM  = 7'b11111_00;
  localparam logic [6:0] C_STALL = 7'b00111_01;
  localparam logic [6:0] C_FLUSH = 7'b11111_10;
  localparam logic [6:0] C_FRZ   = 7'b00000_00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hz_stall = 1'b0, br_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0, cnt_clr = 1'b0;
  logic pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld, if_id_flush, id_nop, timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
    .pc_ld(pc_ld), .if_id_ld(if_id_ld), .id_ex_ld(id_ex_ld), .ex_mem_ld(ex_mem_ld),
    .mem_wb_ld(mem_wb_ld), .if_id_flush(if_id_flush), .id_nop(id_nop),
    .timeout(timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  wire [6:0] ctl_bus = {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld, if_id_flush, id_nop};

  int total = 0;
  int bad   = 0;

  // Behavioural model: outstanding access, its frozen-cycle count, sticky error.
  bit m_busy, m_err;
  int m_frozen, m_stall, m_flush;
  logic [6:0] last_ctl;
  logic       last_to;

  typedef struct {
    logic hz, br, req, ack, clr;
    logic [6:0] ctl;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input logic hz, input logic br, input logic req, input logic ack,
                      input logic clr);
    logic [6:0] exp;
    bit err_now;
    @(negedge clk);
    hz_stall = hz; br_taken = br; mem_req = req; mem_ack = ack; cnt_clr = clr;
    #1;
    err_now = m_err;
    if (m_err) begin
      exp = C_FRZ;
    end else if (m_busy) begin
      if (ack) begin
        exp = C_NORM;
        m_busy = 0;
      end else begin
        exp = C_FRZ;
        m_frozen++;
        if (m_frozen > MEM_TIMEOUT) begin
          m_err = 1;
          m_busy = 0;
        end
      end
    end else if (req && !ack) begin
      exp = C_FRZ;
      m_busy = 1;
      m_frozen = 1;
    end else if (hz) begin
      exp = C_STALL;
    end else if (br) begin
      exp = C_FLUSH;
    end else begin
      exp = C_NORM;
    end
    last_ctl = ctl_bus;
    last_to  = timeout;
    check("ctl", 32'(ctl_bus), 32'(exp));
    check("timeout", 32'(timeout), 32'(err_now));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    if (clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!exp[6] && !err_now && m_stall < CNT_MAX) m_stall++;
      if (exp[1] && m_flush < CNT_MAX) m_flush++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hz_stall = 0; br_taken = 0; mem_req = 0; mem_ack = 0; cnt_clr = 0;
    #1;
    check("rst_ctl", 32'(ctl_bus), 32'(C_FRZ));
    @(posedge clk);
    #1;
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic expect_cnt(input string name, input int s, input int f);
    @(posedge clk);
    #1;
    check({name, "_stall"}, 32'(stall_cnt), 32'(s));
    check({name, "_flush"}, 32'(flush_cnt), 32'(f));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, C_NORM};
    vecs[1]  = '{1, 0, 0, 0, 0, C_STALL};
    vecs[2]  = '{0, 1, 0, 0, 0, C_FLUSH};
    vecs[3]  = '{1, 1, 0, 0, 0, C_STALL};
    vecs[4]  = '{0, 0, 1, 1, 0, C_NORM};
    vecs[5]  = '{0, 1, 1, 1, 0, C_FLUSH};
    vecs[6]  = '{1, 1, 1, 0, 0, C_FRZ};
    vecs[7]  = '{1, 1, 0, 0, 0, C_FRZ};
    vecs[8]  = '{0, 1, 1, 1, 0, C_NORM};
    vecs[9]  = '{0, 1, 0, 0, 1, C_FLUSH};
    vecs[10] = '{1, 0, 0, 0, 1, C_STALL};

    model_reset();
    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].hz, vecs[i].br, vecs[i].req, vecs[i].ack, vecs[i].clr);
      check($sformatf("vec%0d", i), 32'(last_ctl), 32'(vecs[i].ctl));
    end

    // Load-use pulse.
    do_reset();
    step(1, 0, 0, 0, 0);
    check("loaduse_ctl", 32'(last_ctl), 32'(C_STALL));
    step(0, 0, 0, 0, 0);
    expect_cnt("loaduse", 1, 0);

    // Stall wins over branch; branch acts the next cycle.
    do_reset();
    step(1, 1, 0, 0, 0);
    check("brst_n", 32'(last_ctl), 32'(C_STALL));
    step(0, 1, 0, 0, 0);
    check("brst_n1", 32'(last_ctl), 32'(C_FLUSH));
    expect_cnt("brst", 1, 1);

    // Three-cycle memory wait then release.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      check($sformatf("memwait%0d", i), 32'(last_ctl), 32'(C_FRZ));
    end
    step(0, 0, 1, 1, 0);
    check("memwait_ack", 32'(last_ctl), 32'(C_NORM));
    step(1, 0, 0, 0, 0);
    check("memwait_run", 32'(last_ctl), 32'(C_STALL));
    expect_cnt("memwait", 4, 0);

    // Timeout into ERR, sticky until reset; ERR cycles are not counted.
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
    check("tmo_before", 32'(last_to), 32'd0);
    step(0, 0, 1, 1, 1);
    check("tmo_err_ctl", 32'(last_ctl), 32'(C_FRZ));
    check("tmo_err_flag", 32'(last_to), 32'd1);
    for (int i = 0; i < 9; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check($sformatf("tmo_hold%0d", i), 32'(last_to), 32'd1);
    end
    expect_cnt("tmo_err", 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0);
    check("tmo_cleared", 32'(last_to), 32'd0);
    check("tmo_run", 32'(last_ctl), 32'(C_NORM));

    // Saturation and clear.
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
    expect_cnt("sat", 15, 0);
    step(0, 0, 0, 0, 1);
    expect_cnt("sat_clr", 0, 0);

    // Asynchronous reset between edges during MEM_WAIT.
    do_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    mem_ack = 1'b1;
    #1;
    check("async_ld", 32'(ctl_bus), 32'(C_FRZ));
    @(posedge clk);
    #2;
    reset = 1'b0;
    mem_req = 1'b0;
    mem_ack = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0);
    check("async_run", 32'(last_ctl), 32'(C_NORM));
    expect_cnt("async", 0, 0);

    // Randomized traffic with varying memory-ack likelihood.
    do_reset();
    for (int blk = 0; blk < 10; blk++) begin
      int ack_pct;
      ack_pct = (blk % 3 == 0) ? 3 : 20 + 15 * blk;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) == 0) begin
          do_reset();
        end else begin
          step(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 30),
               1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < ack_pct),
               1'($urandom_range(0, 99) < 4));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
